shift_left_seq_32bit: RTL and testbench
=======================================

SHIFT_LEFT_SEQ_32BIT -- requirements
Module: shift_left_seq_32bit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request; sampled only when the block is idle or in DONE.
REQ-006 X  input  32  operand to shift.
REQ-007 Y  input  32  unsigned shift amount.
REQ-008 V  input  1  fill bit shifted into vacated LSB positions.
REQ-009 Z  output  32  result register; holds value until the next result.
REQ-010 busy  output  1  high while an accepted operation is in progress.
REQ-011 done  output  1  one-cycle pulse; Z is valid in the same cycle.

Function
REQ-012 The result SHALL be Z = (X << Y) with the vacated LSBs filled with V, i.e. Z[i] = X[i-Y] if i >= Y, else V.
REQ-013 If Y >= 32 (any bit of Y[31:5] set), the result SHALL be all V.
REQ-014 The state machine SHALL have states IDLE, SHIFT and DONE.
REQ-015 In IDLE or DONE, start=1 at edge E0 SHALL capture X, Y[4:0] and V, and enter SHIFT with stage counter k=4.
  - Capture loads the accumulator with X, or with {32{V}} when Y >= 32.
REQ-016 In SHIFT, each cycle SHALL apply stage k and then decrement k.
  - When Y[k]=1 and Y < 32: acc <= {acc[31-2^k:0], {2^k{V}}}.
  - When Y[k]=0 or Y >= 32: acc is unchanged.
REQ-017 After stage k=0 the FSM SHALL enter DONE, load Z from acc, and assert done.
REQ-018 Latency SHALL be fixed and independent of Y.
  - start sampled at edge E0.
  - busy=1 from E0+1 through E0+5.
  - done=1 and Z valid during the cycle after E0+6.
REQ-019 busy SHALL be 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE, or to SHIFT if start=1 in that cycle (back-to-back, no bubble).
REQ-021 start asserted while in SHIFT SHALL be ignored, with no effect on the operation in progress.
REQ-022 X, Y and V SHALL be don't-care after capture; changes during SHIFT SHALL NOT affect the result.
REQ-023 Z SHALL change only on entry to DONE or on reset.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, Z=0, busy=0, done=0, k=4, acc=0, with priority over start.
REQ-025 Reset during SHIFT SHALL abandon the operation with no done pulse; a start after reset releases behaves normally.

Verification
REQ-026 Basic shift: rst 2 cycles; start with X=0x0000_00F1, Y=4, V=0.
  - busy high for 5 cycles, then done one cycle with Z=0x0000_0F10.
REQ-027 Fill bit: X=0x8000_0001, Y=31, V=1.
  - Z=0xFFFF_FFFF after 6 cycles.
REQ-028 Zero shift: X=0x1234_5678, Y=0, V=1.
  - Z=0x1234_5678.
REQ-029 Out-of-range amounts: X=0xDEAD_BEEF with Y=32, then Y=0x8000_0003.
  - V=0 gives Z=0x0000_0000.
  - V=1 gives Z=0xFFFF_FFFF.
  - Both complete with the same 6-cycle latency.
REQ-030 Handshake corners:
  - start held high through SHIFT is ignored, and X is changed mid-operation; result reflects the captured X.
  - start in the DONE cycle gives the next done exactly 6 cycles later.
REQ-031 Reset mid-operation: rst at E0+3.
  - No done pulse; Z=0, busy=0.
  - A new start with X=1, Y=5, V=0 yields Z=0x0000_0020.

Source files
------------

// File: rtl/shift_left_seq_32bit.sv
// shift_left_seq_32bit: fixed-latency sequential left shifter with programmable fill bit
module shift_left_seq_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        V,
  output logic [31:0] Z,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state;
  logic [2:0]  k;
  logic [31:0] acc;
  logic [4:0]  amt;
  logic        fill;
  logic        oor;
  logic [5:0]  step;
  logic [31:0] staged;
  // one log-shifter stage: shift by 2^k, filling vacated LSBs with the captured fill bit
  always_comb begin
    step   = 6'd1 << k;
    staged = (acc << step) | ({32{fill}} & ~(32'hFFFF_FFFF << step));
  end
  // control FSM; k runs 4..0 applying stages, then wraps to 7 for the fixed final cycle before DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Z     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      k     <= 3'd4;
      acc   <= '0;
      amt   <= '0;
      fill  <= 1'b0;
      oor   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= state == SHIFT && k != 3'd7;
      if (state != SHIFT) begin
        state <= start ? SHIFT : IDLE;
        if (start) begin
          acc  <= |Y[31:5] ? {32{V}} : X;
          amt  <= Y[4:0];
          fill <= V;
          oor  <= |Y[31:5];
          k    <= 3'd4;
        end
      end else if (k == 3'd7) begin
        state <= DONE;
        Z     <= acc;
        done  <= 1'b1;
        k     <= 3'd4;
      end else begin
        if (amt[k] && !oor) acc <= staged;
        k <= k - 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_shift_left_seq_32bit.sv
// tb_shift_left_seq_32bit: vector table, handshake corners and random ops against a reference model
module tb_shift_left_seq_32bit;
  logic        clk = 0;
  logic        rst, start, V;
  logic [31:0] X, Y;
  logic [31:0] Z;
  logic        busy, done;
  int          checks = 0;
  int          failures = 0;

  shift_left_seq_32bit dut (.clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .V(V),
                            .Z(Z), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        v;
    logic [31:0] z;
  } vec_t;

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [31:0] y, input logic v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (y < 32 && i >= y) ? x[i - y] : v;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // caller places time away from a clock edge; inputs presented now, sampled at next edge (E0)
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic v,
                       input bit hold, input bit scramble,
                       output int lat, output int bcnt, output logic [31:0] zo);
    X = x; Y = y; V = v; start = 1;
    @(posedge clk); #1;
    start = hold;
    lat = 0; bcnt = 0; zo = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c; zo = Z; start = 0;
        break;
      end
      if (busy) bcnt++;
      if (scramble) begin X = $urandom; Y = $urandom; V = 1'($urandom); end
    end
    start = 0;
  endtask

  vec_t        vecs[10];
  int          lat, bcnt, seen;
  logic [31:0] zo, ex, yr, xr;
  logic        vr;

  initial begin
    vecs[0] = '{32'h0000_00F1, 32'd4,          1'b0, 32'h0000_0F10};
    vecs[1] = '{32'h8000_0001, 32'd31,         1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{32'h1234_5678, 32'd0,          1'b1, 32'h1234_5678};
    vecs[3] = '{32'hDEAD_BEEF, 32'd32,         1'b0, 32'h0000_0000};
    vecs[4] = '{32'hDEAD_BEEF, 32'd32,         1'b1, 32'hFFFF_FFFF};
    vecs[5] = '{32'hDEAD_BEEF, 32'h8000_0003,  1'b0, 32'h0000_0000};
    vecs[6] = '{32'hDEAD_BEEF, 32'h8000_0003,  1'b1, 32'hFFFF_FFFF};
    vecs[7] = '{32'h0000_FFFF, 32'd16,         1'b1, 32'hFFFF_FFFF};
    vecs[8] = '{32'hA5A5_A5A5, 32'd1,          1'b1, 32'h4B4B_4B4B};
    vecs[9] = '{32'h8000_0000, 32'd31,         1'b0, 32'h0000_0000};
    rst = 1; start = 0; X = 0; Y = 0; V = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset_z", Z, 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      do_op(vecs[i].x, vecs[i].y, vecs[i].v, 0, 0, lat, bcnt, zo);
      check($sformatf("vec%0d_latency", i), 32'(lat), 6);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 5);
      check($sformatf("vec%0d_z", i), zo, vecs[i].z);
    end

    // Z holds and done drops after the pulse
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 0);
    repeat (2) @(posedge clk); #1;
    check("z_hold", Z, vecs[9].z);

    // start held through SHIFT with inputs scrambled mid-operation
    @(negedge clk);
    do_op(32'h0F0F_0001, 32'd8, 1'b1, 1, 1, lat, bcnt, zo);
    check("hold_latency", 32'(lat), 6);
    check("hold_z", zo, 32'h0F00_01FF);

    // back-to-back: start presented in the DONE cycle
    @(negedge clk);
    do_op(32'h0000_0003, 32'd2, 1'b0, 0, 0, lat, bcnt, zo);
    check("b2b_first_z", zo, 32'h0000_000C);
    do_op(32'h0000_0003, 32'd3, 1'b1, 0, 0, lat, bcnt, zo);
    check("b2b_latency", 32'(lat), 6);
    check("b2b_second_z", zo, 32'h0000_001F);

    // reset at E0+3 abandons the operation
    @(negedge clk);
    X = 32'hFFFF_0000; Y = 32'd1; V = 1; start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    check("midrst_z", Z, 0);
    check("midrst_busy", 32'(busy), 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst_no_done", 32'(seen), 0);
    @(negedge clk);
    do_op(32'd1, 32'd5, 1'b0, 0, 0, lat, bcnt, zo);
    check("after_rst_latency", 32'(lat), 6);
    check("after_rst_z", zo, 32'h0000_0020);

    // random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      xr = $urandom;
      yr = (n % 5 == 4) ? $urandom : 32'($urandom_range(0, 40));
      vr = 1'($urandom);
      ex = ref_shift(xr, yr, vr);
      @(negedge clk);
      do_op(xr, yr, vr, 1'($urandom), 1, lat, bcnt, zo);
      check($sformatf("rand%0d_latency", n), 32'(lat), 6);
      check($sformatf("rand%0d_z x=%08h y=%08h v=%0d", n, xr, yr, vr), zo, ex);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
